// File: rtl/serial_subtractor_nbit.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor_nbit
// Purpose  : Bit-serial subtractor, diff = a - b - borrow_in, one bit per
//            clock, LSB first, with a start/busy/done handshake.
//            Optional macro SUB_SIGNED_OVF_EN enables the signed overflow
//            flag; when undefined, overflow is tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module serial_subtractor_nbit #(
    parameter int BIT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 borrow_in,
    output logic                 busy,
    output logic                 done,
    output logic [BIT_WIDTH-1:0] diff,
    output logic                 borrow_out,
    output logic                 overflow
);

    localparam int c_cnt_w = (BIT_WIDTH > 2) ? $clog2(BIT_WIDTH) : 1;
    localparam logic [c_cnt_w-1:0] c_last_cnt = c_cnt_w'(BIT_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;
    logic [BIT_WIDTH-1:0] r_a_sr;
    logic [BIT_WIDTH-1:0] r_b_sr;
    logic                 r_br;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 w_accept;
    logic                 w_last;
    logic                 w_d;
    logic                 w_br_next;

    // A new operation may be launched from IDLE or straight out of DONE.
    assign w_accept  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_last    = (r_state == ST_BUSY) && (r_cnt == c_last_cnt);

    // Single full-subtractor cell operating on the current LSBs.
    assign w_d       = r_a_sr[0] ^ r_b_sr[0] ^ r_br;
    assign w_br_next = (~r_a_sr[0] & r_b_sr[0]) | (~(r_a_sr[0] ^ r_b_sr[0]) & r_br);

    // State register.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and handshake outputs decoded from the state.
    always_comb begin
        w_state_next = r_state;
        busy         = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = ST_BUSY;
            end
            ST_BUSY: begin
                busy = 1'b1;
                if (w_last) w_state_next = ST_DONE;
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = w_accept ? ST_BUSY : ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Operand shift registers, running borrow, result shifter and counter.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_a_sr     <= '0;
            r_b_sr     <= '0;
            r_br       <= 1'b0;
            r_cnt      <= '0;
            diff       <= '0;
            borrow_out <= 1'b0;
        end else if (w_accept) begin
            r_a_sr <= a;
            r_b_sr <= b;
            r_br   <= borrow_in;
            r_cnt  <= '0;
        end else if (r_state == ST_BUSY) begin
            r_a_sr <= r_a_sr >> 1;
            r_b_sr <= r_b_sr >> 1;
            r_br   <= w_br_next;
            diff   <= {w_d, diff[BIT_WIDTH-1:1]};
            r_cnt  <= r_cnt + 1'b1;
            // Borrow out of the MSB cell is the final unsigned borrow.
            if (w_last) borrow_out <= w_br_next;
        end
    end

`ifdef SUB_SIGNED_OVF_EN
    logic r_a_msb;
    logic r_b_msb;

    // Capture operand signs at start; on the last bit the MSB of the result
    // is w_d, so the flag lands together with entry to DONE.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_a_msb  <= 1'b0;
            r_b_msb  <= 1'b0;
            overflow <= 1'b0;
        end else if (w_accept) begin
            r_a_msb <= a[BIT_WIDTH-1];
            r_b_msb <= b[BIT_WIDTH-1];
        end else if (w_last) begin
            overflow <= (r_a_msb != r_b_msb) && (w_d != r_a_msb);
        end
    end
`else
    assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_subtractor_nbit.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_subtractor_nbit
// Purpose  : Self-checking bench for serial_subtractor_nbit: directed vector
//            table, handshake corner sequences and random operands checked
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_subtractor_nbit;

    localparam int W = 8;

`ifdef SUB_SIGNED_OVF_EN
    localparam logic c_ovf_on = 1'b1;
`else
    localparam logic c_ovf_on = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         n_rst = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         borrow_in = 1'b0;
    logic         busy;
    logic         done;
    logic [W-1:0] diff;
    logic         borrow_out;
    logic         overflow;

    int total = 0;
    int bad   = 0;

    serial_subtractor_nbit #(.BIT_WIDTH(W)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .start      (start),
        .a          (a),
        .b          (b),
        .borrow_in  (borrow_in),
        .busy       (busy),
        .done       (done),
        .diff       (diff),
        .borrow_out (borrow_out),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] va;
        logic [W-1:0] vb;
        logic         vbin;
        logic [W-1:0] ediff;
        logic         ebout;
        logic         eovf;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference model: plain arithmetic on the operands.
    function automatic logic [W+1:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mbin);
        logic [W:0] full;
        int         s;
        logic       ovf;
        full = {1'b0, ma} - {1'b0, mb} - {{W{1'b0}}, mbin};
        s    = $signed(ma) - $signed(mb) - int'(mbin);
        ovf  = c_ovf_on && ((s > (2 ** (W - 1)) - 1) || (s < -(2 ** (W - 1))));
        return {ovf, full[W], full[W-1:0]};
    endfunction

    // Launch at the next rising edge; scramble inputs afterwards.
    task automatic launch(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tbin);
        @(negedge clk);
        a = ta; b = tb_v; borrow_in = tbin; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); borrow_in = 1'($urandom);
    endtask

    // Called at #1 after the accepting edge; returns edges until done is seen.
    task automatic wait_done(output int edges);
        edges = -1;
        for (int i = 1; i <= 3 * W; i++) begin
            @(posedge clk); #1;
            if (done) begin
                edges = i;
                break;
            end
        end
        if (edges < 0) begin
            total++; bad++;
            $display("FAIL done_timeout: got=none expected=done within %0d cycles", 3 * W);
        end
    endtask

    task automatic check_result(input string name, input logic [W-1:0] ta,
                                input logic [W-1:0] tb_v, input logic tbin);
        logic [W+1:0] m;
        m = model(ta, tb_v, tbin);
        check({name, "_diff"}, diff, m[W-1:0]);
        check({name, "_bout"}, borrow_out, m[W]);
        check({name, "_ovf"}, overflow, m[W+1]);
    endtask

    initial begin
        int           edges;
        logic [W-1:0] ra, rb;
        logic         rbin;

        vecs[0] = '{8'd100, 8'd37, 1'b0, 8'd63,  1'b0, 1'b0};
        vecs[1] = '{8'd5,   8'd10, 1'b0, 8'hFB,  1'b1, 1'b0};
        vecs[2] = '{8'h00,  8'h00, 1'b1, 8'hFF,  1'b1, 1'b0};
        vecs[3] = '{8'h80,  8'h01, 1'b0, 8'h7F,  1'b0, c_ovf_on};
        vecs[4] = '{8'h7F,  8'hFF, 1'b0, 8'h80,  1'b1, c_ovf_on};
        vecs[5] = '{8'hFF,  8'hFF, 1'b1, 8'hFF,  1'b1, 1'b0};

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_diff", diff, 0);
        check("rst_bout", borrow_out, 0);
        check("rst_ovf", overflow, 0);
        @(negedge clk); n_rst = 1'b1;

        // Directed table with exact latency.
        for (int i = 0; i < 6; i++) begin
            launch(vecs[i].va, vecs[i].vb, vecs[i].vbin);
            check("busy_after_start", busy, 1);
            wait_done(edges);
            check("latency", edges + 1, W + 1);
            check("tbl_diff", diff, vecs[i].ediff);
            check("tbl_bout", borrow_out, vecs[i].ebout);
            check("tbl_ovf", overflow, vecs[i].eovf);
            @(posedge clk); #1;
            check("done_one_cycle", done, 0);
            check("hold_diff", diff, vecs[i].ediff);
        end

        // start pulses in BUSY cycles 3 and 5 are ignored.
        launch(8'd200, 8'd55, 1'b0);
        for (int c = 2; c <= 5; c++) begin
            @(negedge clk);
            if (c == 3 || c == 5) begin
                start = 1'b1; a = 8'd1; b = 8'd2; borrow_in = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        edges = 0;
        for (int i = 1; i <= 3 * W && !done; i++) begin
            @(posedge clk); #1;
            edges = i;
        end
        check("ign_done_seen", done, 1);
        check("ign_latency", edges + 5, W + 1);
        check_result("ignore", 8'd200, 8'd55, 1'b0);

        // Back-to-back: start held in the DONE cycle.
        launch(8'd10, 8'd3, 1'b0);
        wait_done(edges);
        check_result("b2b_first", 8'd10, 8'd3, 1'b0);
        a = 8'h33; b = 8'h44; borrow_in = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("b2b_busy", busy, 1);
        wait_done(edges);
        check("b2b_latency", edges + 1, W + 1);
        check_result("b2b_second", 8'h33, 8'h44, 1'b1);

        // Asynchronous reset mid-operation.
        launch(8'h80, 8'h01, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        n_rst = 1'b0;
        #1;
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        check("arst_diff", diff, 0);
        check("arst_bout", borrow_out, 0);
        check("arst_ovf", overflow, 0);
        @(negedge clk); n_rst = 1'b1;
        edges = 0;
        for (int i = 0; i < 2 * W; i++) begin
            @(posedge clk); #1;
            if (done || busy) edges++;
        end
        check("arst_no_done", edges, 0);
        launch(8'd100, 8'd37, 1'b0);
        wait_done(edges);
        check("arst_recover_lat", edges + 1, W + 1);
        check_result("arst_recover", 8'd100, 8'd37, 1'b0);

        // Random operands against the model.
        for (int n = 0; n < 40; n++) begin
            ra = W'($urandom); rb = W'($urandom); rbin = 1'($urandom);
            launch(ra, rb, rbin);
            wait_done(edges);
            check("rnd_latency", edges + 1, W + 1);
            check_result("rnd", ra, rb, rbin);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
